// File: rtl/cpu_pkg.sv
// Shared constants for the shift-add multiplier CPU: opcodes, operand sources,
// loader state encoding and the built-in multiply program.
package cpu_pkg;

  localparam logic [3:0] OP_CLEAR_LOAD  = 4'h0;
  localparam logic [3:0] OP_ADD_LOAD    = 4'h1;
  localparam logic [3:0] OP_ADD         = 4'h2;
  localparam logic [3:0] OP_SHIFT_RIGHT = 4'h3;
  localparam logic [3:0] OP_DISP        = 4'h4;
  localparam logic [3:0] OP_HALT        = 4'hF;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_A    = 2'd1;
  localparam logic [1:0] SRC_B    = 2'd2;
  localparam logic [1:0] SRC_IMM  = 2'd3;

  typedef enum logic [1:0] {
    LdIdle    = 2'd0,
    LdLoading = 2'd1,
    LdFull    = 2'd2
  } ld_state_e;

  // Opcode of the built-in multiply program at a given entry.
  function automatic logic [3:0] default_opcode(input int unsigned idx);
    logic [3:0] op;
    case (idx)
      0:       op = OP_CLEAR_LOAD;
      1:       op = OP_ADD_LOAD;
      2:       op = OP_ADD;
      3:       op = OP_SHIFT_RIGHT;
      4:       op = OP_DISP;
      default: op = OP_HALT;
    endcase
    return op;
  endfunction

  // Operand source of the built-in multiply program at a given entry.
  function automatic logic [1:0] default_src(input int unsigned idx);
    logic [1:0] src;
    case (idx)
      1:       src = SRC_A;
      2:       src = SRC_B;
      default: src = SRC_NONE;
    endcase
    return src;
  endfunction

endpackage

// File: rtl/instr_loader_fsm.sv
// Sequential program loader: tracks the write pointer and full flag and
// produces the write strobe/address for the instruction array.
module instr_loader_fsm #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   load_ptr,
  output logic              load_full
);
  import cpu_pkg::*;

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  ld_state_e       state_q;
  logic [ADDR_W:0] base_ptr;
  logic [ADDR_W:0] ptr_inc;

  // A load_start restarts at entry 0 even when a word arrives on the same edge.
  always_comb begin
    base_ptr = load_start ? '0 : load_ptr;
    ptr_inc  = base_ptr + (ADDR_W + 1)'(1);
    wr_en    = load_valid && (load_start || (state_q == LdLoading));
    wr_addr  = base_ptr[ADDR_W-1:0];
  end

  // Loader state, pointer and full flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= LdIdle;
      load_ptr  <= '0;
      load_full <= 1'b0;
    end else if (wr_en) begin
      load_ptr <= ptr_inc;
      if (ptr_inc == DepthW) begin
        state_q   <= LdFull;
        load_full <= 1'b1;
      end else begin
        state_q   <= LdLoading;
        load_full <= 1'b0;
      end
    end else if (load_start) begin
      state_q   <= LdLoading;
      load_ptr  <= '0;
      load_full <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_rom_loadable.sv
// Run-time loadable program memory: DEPTH entries of {opcode, src, imm},
// registered fetch with operand-source mux, reset to the built-in program.
module instr_rom_loadable #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_en,
  input  logic [ADDR_W-1:0]      pc,
  input  logic [DATA_W-1:0]      op_a,
  input  logic [DATA_W-1:0]      op_b,
  output logic [OP_W-1:0]        opcode,
  output logic [DATA_W-1:0]      data,
  output logic                   valid,
  output logic                   pc_err,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [OP_W+2+DATA_W-1:0] load_word,
  output logic [ADDR_W:0]        load_ptr,
  output logic                   load_full
);
  import cpu_pkg::*;

  localparam int unsigned     WordW  = OP_W + 2 + DATA_W;
  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  logic [OP_W-1:0]   mem_op  [DEPTH];
  logic [1:0]        mem_src [DEPTH];
  logic [DATA_W-1:0] mem_imm [DEPTH];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [OP_W-1:0]   word_op;
  logic [1:0]        word_src;
  logic [DATA_W-1:0] word_imm;

  logic              in_range;
  logic [OP_W-1:0]   rd_op;
  logic [1:0]        rd_src;
  logic [DATA_W-1:0] rd_imm;

  instr_loader_fsm #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_loader (
    .clock     (clock),
    .reset     (reset),
    .load_start(load_start),
    .load_valid(load_valid),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .load_ptr  (load_ptr),
    .load_full (load_full)
  );

  // Split the incoming load word into its fields.
  always_comb begin
    word_op  = load_word[WordW-1 -: OP_W];
    word_src = load_word[DATA_W +: 2];
    word_imm = load_word[DATA_W-1:0];
  end

  // Instruction array: reset restores the built-in program, loader overwrites.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (reset) begin
        mem_op[i]  <= OP_W'(default_opcode(i));
        mem_src[i] <= default_src(i);
        mem_imm[i] <= '0;
      end else if (wr_en && (wr_addr == ADDR_W'(i))) begin
        mem_op[i]  <= word_op;
        mem_src[i] <= word_src;
        mem_imm[i] <= word_imm;
      end
    end
  end

  // Read port; compare-select avoids indexing past DEPTH when pc is out of range.
  always_comb begin
    in_range = {1'b0, pc} < DepthW;
    rd_op    = '0;
    rd_src   = SRC_NONE;
    rd_imm   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (pc == ADDR_W'(i)) begin
        rd_op  = mem_op[i];
        rd_src = mem_src[i];
        rd_imm = mem_imm[i];
      end
    end
  end

  // Fetch register: reads old array contents when a write hits the same entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      opcode <= OP_W'(OP_HALT);
      data   <= '0;
      valid  <= 1'b0;
      pc_err <= 1'b0;
    end else if (fetch_en) begin
      valid  <= 1'b1;
      pc_err <= !in_range;
      if (in_range) begin
        opcode <= rd_op;
        case (rd_src)
          SRC_A:   data <= op_a;
          SRC_B:   data <= op_b;
          SRC_IMM: data <= rd_imm;
          default: data <= data;
        endcase
      end else begin
        opcode <= OP_W'(OP_HALT);
      end
    end else begin
      valid  <= 1'b0;
      pc_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_rom_loadable.sv
// Bench for instr_rom_loadable: directed scenarios plus randomized traffic
// checked against an array-based reference model.
module tb_instr_rom_loadable;

  localparam int unsigned DEPTH = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b0, fetch_en = 1'b0, load_start = 1'b0, load_valid = 1'b0;
  logic [3:0] pc = '0, op_a = '0, op_b = '0;
  logic [9:0] load_word = '0;
  logic [3:0] opcode, data;
  logic       valid, pc_err, load_full;
  logic [4:0] load_ptr;

  logic       fetch_en6 = 1'b0, load_start6 = 1'b0, load_valid6 = 1'b0;
  logic [3:0] pc6 = '0;
  logic [9:0] load_word6 = '0;
  logic [3:0] opcode6, data6;
  logic       valid6, pc_err6, load_full6;
  logic [4:0] load_ptr6;

  int tests_run = 0;
  int failed    = 0;

  instr_rom_loadable #(.DATA_W(4), .OP_W(4), .ADDR_W(4), .DEPTH(16)) dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en), .pc(pc), .op_a(op_a), .op_b(op_b),
    .opcode(opcode), .data(data), .valid(valid), .pc_err(pc_err),
    .load_start(load_start), .load_valid(load_valid), .load_word(load_word),
    .load_ptr(load_ptr), .load_full(load_full)
  );

  instr_rom_loadable #(.DATA_W(4), .OP_W(4), .ADDR_W(4), .DEPTH(6)) dut6 (
    .clock(clock), .reset(reset), .fetch_en(fetch_en6), .pc(pc6), .op_a(op_a), .op_b(op_b),
    .opcode(opcode6), .data(data6), .valid(valid6), .pc_err(pc_err6),
    .load_start(load_start6), .load_valid(load_valid6), .load_word(load_word6),
    .load_ptr(load_ptr6), .load_full(load_full6)
  );

  // Reference model of the 16-entry instance.
  logic [3:0] m_op  [DEPTH];
  logic [1:0] m_src [DEPTH];
  logic [3:0] m_imm [DEPTH];
  logic [3:0] m_opcode, m_data;
  logic       m_valid, m_err, m_full, m_loading;
  logic [4:0] m_ptr;

  function automatic logic [9:0] mk(input logic [3:0] op, input logic [1:0] src,
                                    input logic [3:0] imm);
    return {op, src, imm};
  endfunction

  function automatic void model_step();
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_op[i]  = (i < 5) ? 4'(i) : 4'hF;
        m_src[i] = (i == 1) ? 2'd1 : (i == 2) ? 2'd2 : 2'd0;
        m_imm[i] = 4'h0;
      end
      m_opcode = 4'hF; m_data = 4'h0; m_valid = 1'b0; m_err = 1'b0;
      m_ptr = 5'd0; m_full = 1'b0; m_loading = 1'b0;
      return;
    end
    if (fetch_en) begin
      m_valid = 1'b1;
      m_err   = 1'b0;
      m_opcode = m_op[pc];
      if (m_src[pc] == 2'd1) m_data = op_a;
      else if (m_src[pc] == 2'd2) m_data = op_b;
      else if (m_src[pc] == 2'd3) m_data = m_imm[pc];
    end else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
    end
    if (load_start) begin
      m_ptr = 5'd0; m_full = 1'b0; m_loading = 1'b1;
    end
    if (load_valid && m_loading) begin
      m_op[m_ptr[3:0]]  = load_word[9:6];
      m_src[m_ptr[3:0]] = load_word[5:4];
      m_imm[m_ptr[3:0]] = load_word[3:0];
      m_ptr = m_ptr + 5'd1;
      if (m_ptr == 5'(DEPTH)) begin
        m_full = 1'b1; m_loading = 1'b0;
      end
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b1; load_word = mk(4'h4, 2'd3, 4'h7); fetch_en = 1'b1;
    tick();
    reset = 1'b0; load_valid = 1'b0; fetch_en = 1'b0;
    tests_run++;
    if (opcode !== 4'hF) begin failed++; $display("FAIL reset_opcode got %h want f", opcode); end
    tests_run++;
    if (data !== 4'h0) begin failed++; $display("FAIL reset_data got %h want 0", data); end
    tests_run++;
    if (valid !== 1'b0 || pc_err !== 1'b0) begin
      failed++; $display("FAIL reset_flags got valid=%b err=%b want 0 0", valid, pc_err);
    end
    tests_run++;
    if (load_ptr !== 5'd0 || load_full !== 1'b0) begin
      failed++; $display("FAIL reset_loader got ptr=%0d full=%b want 0 0", load_ptr, load_full);
    end
    tests_run++;
    if (opcode6 !== 4'hF) begin failed++; $display("FAIL reset_opcode6 got %h want f", opcode6); end
  endtask

  task automatic test_default_program();
    logic [3:0] exp_data [5];
    exp_data = '{4'h0, 4'h3, 4'h5, 4'h5, 4'h5};
    op_a = 4'h3; op_b = 4'h5; fetch_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc = 4'(i);
      tick();
      tests_run++;
      if (opcode !== 4'(i) || data !== exp_data[i] || valid !== 1'b1) begin
        failed++;
        $display("FAIL default_pc%0d got op=%h data=%h valid=%b want op=%h data=%h valid=1",
                 i, opcode, data, valid, 4'(i), exp_data[i]);
      end
    end
    pc = 4'd7;
    tick();
    tests_run++;
    if (opcode !== 4'hF || data !== 4'h5 || pc_err !== 1'b0) begin
      failed++;
      $display("FAIL default_pc7 got op=%h data=%h err=%b want f 5 0", opcode, data, pc_err);
    end
    fetch_en = 1'b0; pc = 4'd1;
    tick();
    tests_run++;
    if (valid !== 1'b0 || opcode !== 4'hF || data !== 4'h5) begin
      failed++;
      $display("FAIL idle_hold got valid=%b op=%h data=%h want 0 f 5", valid, opcode, data);
    end
  endtask

  task automatic test_pc_err();
    fetch_en6 = 1'b1; pc6 = 4'd5;
    tick();
    tests_run++;
    if (opcode6 !== 4'hF || pc_err6 !== 1'b0 || valid6 !== 1'b1) begin
      failed++;
      $display("FAIL d6_pc5 got op=%h err=%b valid=%b want f 0 1", opcode6, pc_err6, valid6);
    end
    pc6 = 4'd9;
    tick();
    tests_run++;
    if (opcode6 !== 4'hF || pc_err6 !== 1'b1 || valid6 !== 1'b1 || data6 !== 4'h0) begin
      failed++;
      $display("FAIL d6_pc9 got op=%h err=%b valid=%b data=%h want f 1 1 0",
               opcode6, pc_err6, valid6, data6);
    end
    fetch_en6 = 1'b0;
    tick();
    tests_run++;
    if (pc_err6 !== 1'b0 || valid6 !== 1'b0) begin
      failed++; $display("FAIL d6_err_pulse got err=%b valid=%b want 0 0", pc_err6, valid6);
    end
  endtask

  task automatic test_full_load();
    fetch_en = 1'b0; load_start = 1'b1;
    tick();
    load_start = 1'b0;
    tests_run++;
    if (load_ptr !== 5'd0 || load_full !== 1'b0) begin
      failed++; $display("FAIL load_begin got ptr=%0d full=%b want 0 0", load_ptr, load_full);
    end
    load_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_word = mk(4'h2, 2'd3, 4'(i));
      tick();
    end
    tests_run++;
    if (load_ptr !== 5'd16 || load_full !== 1'b1) begin
      failed++; $display("FAIL load_full got ptr=%0d full=%b want 16 1", load_ptr, load_full);
    end
    load_word = mk(4'h4, 2'd3, 4'hE);
    tick();
    load_valid = 1'b0;
    tests_run++;
    if (load_ptr !== 5'd16 || load_full !== 1'b1) begin
      failed++; $display("FAIL load_extra got ptr=%0d full=%b want 16 1", load_ptr, load_full);
    end
    fetch_en = 1'b1; pc = 4'd10;
    tick();
    tests_run++;
    if (opcode !== 4'h2 || data !== 4'hA) begin
      failed++; $display("FAIL load_pc10 got op=%h data=%h want 2 a", opcode, data);
    end
    pc = 4'd0;
    tick();
    tests_run++;
    if (opcode !== 4'h2 || data !== 4'h0) begin
      failed++; $display("FAIL load_pc0 got op=%h data=%h want 2 0", opcode, data);
    end
  endtask

  task automatic test_rw_same_cycle();
    fetch_en = 1'b1; pc = 4'd0;
    load_start = 1'b1; load_valid = 1'b1; load_word = mk(4'h4, 2'd3, 4'h9);
    tick();
    load_start = 1'b0; load_valid = 1'b0;
    tests_run++;
    if (opcode !== 4'h2 || data !== 4'h0) begin
      failed++; $display("FAIL rbw_old got op=%h data=%h want 2 0", opcode, data);
    end
    tests_run++;
    if (load_ptr !== 5'd1 || load_full !== 1'b0) begin
      failed++; $display("FAIL start_valid got ptr=%0d full=%b want 1 0", load_ptr, load_full);
    end
    tick();
    tests_run++;
    if (opcode !== 4'h4 || data !== 4'h9) begin
      failed++; $display("FAIL rbw_new got op=%h data=%h want 4 9", opcode, data);
    end
  endtask

  task automatic test_partial_load();
    logic [3:0] b;
    b = 4'($urandom_range(0, 15));
    op_b = b; fetch_en = 1'b0; load_start = 1'b1;
    tick();
    load_start = 1'b0; load_valid = 1'b1; load_word = mk(4'h4, 2'd3, 4'h6);
    tick();
    tick();
    load_valid = 1'b0; fetch_en = 1'b1; pc = 4'd1;
    tick();
    tests_run++;
    if (opcode !== 4'h4 || data !== 4'h6 || load_ptr !== 5'd2) begin
      failed++;
      $display("FAIL partial_new got op=%h data=%h ptr=%0d want 4 6 2", opcode, data, load_ptr);
    end
    pc = 4'd2;
    tick();
    tests_run++;
    if (opcode !== 4'h2 || data !== 4'h2) begin
      failed++; $display("FAIL partial_old got op=%h data=%h want 2 2", opcode, data);
    end
    fetch_en = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [3:0] a;
    a = 4'($urandom_range(0, 15));
    fetch_en = 1'b0; load_start = 1'b1;
    tick();
    load_start = 1'b0; load_valid = 1'b1; load_word = mk(4'h3, 2'd3, 4'h7);
    for (int i = 0; i < 3; i++) tick();
    load_valid = 1'b0;
    tests_run++;
    if (load_ptr !== 5'd3) begin failed++; $display("FAIL mid_ptr got %0d want 3", load_ptr); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests_run++;
    if (load_ptr !== 5'd0 || load_full !== 1'b0) begin
      failed++; $display("FAIL mid_reset got ptr=%0d full=%b want 0 0", load_ptr, load_full);
    end
    op_a = a; fetch_en = 1'b1; pc = 4'd1;
    tick();
    tests_run++;
    if (opcode !== 4'h1 || data !== a) begin
      failed++; $display("FAIL mid_pc1 got op=%h data=%h want 1 %h", opcode, data, a);
    end
    fetch_en = 1'b0; load_valid = 1'b1; load_word = mk(4'hF, 2'd3, 4'hC);
    tick();
    load_valid = 1'b0;
    tests_run++;
    if (load_ptr !== 5'd0) begin failed++; $display("FAIL idle_write got ptr=%0d want 0", load_ptr); end
    fetch_en = 1'b1; pc = 4'd0;
    tick();
    tests_run++;
    if (opcode !== 4'h0 || data !== a) begin
      failed++; $display("FAIL idle_pc0 got op=%h data=%h want 0 %h", opcode, data, a);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      load_start = ($urandom_range(0, 19) == 0);
      load_valid = ($urandom_range(0, 1) == 1);
      load_word  = 10'($urandom);
      fetch_en   = ($urandom_range(0, 3) != 0);
      pc         = 4'($urandom_range(0, 15));
      op_a       = 4'($urandom_range(0, 15));
      op_b       = 4'($urandom_range(0, 15));
      tick();
      tests_run++;
      if (opcode !== m_opcode || data !== m_data || valid !== m_valid || pc_err !== m_err ||
          load_ptr !== m_ptr || load_full !== m_full) begin
        failed++;
        $display("FAIL random_%0d got op=%h d=%h v=%b e=%b p=%0d f=%b want %h %h %b %b %0d %b",
                 n, opcode, data, valid, pc_err, load_ptr, load_full,
                 m_opcode, m_data, m_valid, m_err, m_ptr, m_full);
      end
    end
    reset = 1'b0; load_start = 1'b0; load_valid = 1'b0; fetch_en = 1'b0;
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_default_program();
    test_pc_err();
    test_full_load();
    test_rw_same_cycle();
    test_partial_load();
    test_reset_mid_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
